icache_assoc: RTL
=================

Name: icache_assoc

Overview:
- Parametrised, set-associative, multi-word-block instruction cache.
- Next-generation replacement for the fixed icache instantiated inside the caches wrapper.
- Sits between the datapath fetch port (imemREN/imemaddr/ihit/imemload) and the memory-controller instruction port (iREN/iaddr/iload/iwait).
- Fills whole blocks word by word on a miss; uses per-set round-robin replacement.

Parameters:
- SETS, 8, number of sets; power of two, ≥2.
- WAYS, 2, associativity; power of two, 1..8.
- BLOCK_WORDS, 2, 32-bit words per block; power of two, 1..8.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- iflush  in  1  invalidate all lines.
- ihit  out  1  imemload valid this cycle.
- imemload  out  32  fetched instruction.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address, bits [1:0]=0.
- iload  in  32  memory read data.
- iwait  in  1  memory busy; data is valid on a cycle with iREN=1 and iwait=0.

Behaviour:
- Address split, with BO=log2(BLOCK_WORDS) and IX=log2(SETS):
  - word offset = imemaddr[2+BO-1:2]
  - index = next IX bits
  - tag = remaining upper bits
- Reset (async): all valid bits=0, victim pointers=0, state=IDLE, fill counter=0. Outputs: ihit=0, iREN=0, iaddr=0, imemload=0. Tag/data arrays are not reset.
- IDLE, hit:
  - Combinational compare of all ways in the indexed set.
  - A hit is imemREN & valid & tag match in any way.
  - On hit: ihit=1 and imemload=matching way's word, in the same cycle (0-cycle latency).
  - Multiple matching ways cannot occur; the lowest matching way wins.
- IDLE, miss (imemREN=1, no match):
  - ihit=0.
  - Latch tag/index into the fill registers.
  - Choose the victim: lowest-numbered invalid way, else the set's round-robin pointer.
  - Go to FILL next cycle with counter=0.
- FILL:
  - iREN=1; iaddr={latched tag, latched index, counter, 2'b00}.
  - On a cycle with iwait=0: write iload into data[victim][index][counter] and increment counter.
  - When the last word (counter=BLOCK_WORDS-1) is accepted:
    - set valid and tag for the victim way;
    - if the victim was the pointer choice, advance the pointer mod WAYS;
    - return to IDLE.
  - The next cycle re-evaluates and hits.
  - Miss penalty = BLOCK_WORDS accepted words + 1 IDLE cycle.
- During FILL: ihit=0 and imemload=0, regardless of imemREN. Changing imemaddr or dropping imemREN does not abort the fill.
- iflush:
  - Any cycle: all valid bits clear at the next edge; state→IDLE; counter=0. Pointers are not reset.
  - Aborts an in-progress fill; the partially written line stays invalid.
  - ihit is forced 0 in the flush cycle.
- Simultaneous iflush and last fill word: flush wins; the line is not validated.
- WAYS=1: victim is always way 0; no pointer.
- BLOCK_WORDS=1: counter width is 1 and always 0.
- Outputs are undriven-free: iREN=0 in IDLE.

Optional Feature:
- Macro ICACHE_STATS_EN adds output ports hit_count[31:0] and miss_count[31:0], both reset to 0.
- hit_count increments on each cycle with ihit=1.
- miss_count increments on each IDLE→FILL transition.
- Both counters saturate at 32'hFFFFFFFF and are not cleared by iflush.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package icache_pkg:
  - icache_state_t enum {IDLE, FILL};
  - helper localparam functions for offset/index/tag widths.
- Reuse word_t from cpu_types_pkg.
- Sub-module icache_way:
  - one way's valid/tag/data arrays;
  - write port (index, word, data, set-valid, tag);
  - flush input;
  - combinational read outputs (valid, tag, word at index/offset).
- icache_assoc instantiates WAYS copies and contains the FSM, victim selection and round-robin pointers.

Test Plan:
- Reset then fetch 0x00000040, iwait=1 for 2 cycles before each word (defaults) → two miss fills at iaddr 0x40 and 0x44; ihit=1 one cycle after the second word; imemload=mem[0x40]. Then fetch 0x44 → same-cycle hit.
- Fetch 0x40, then 0x240 (same index, different tag) → the second fill goes to way 1 (invalid). Then 0x440 → evicts way 0 (pointer=0, advances to 1). Refetch 0x240 hits; 0x40 misses.
- iflush during the second word of a fill at 0x80 → no ihit; refetch 0x80 re-misses and refills both words.
- Drop imemREN and change imemaddr to 0x100 mid-fill of 0xC0 → fill completes at 0xC0/0xC4; a later 0xC0 fetch hits with zero memory requests.
- Parameters SETS=4, WAYS=4, BLOCK_WORDS=4: fetch 0x1000 → four words at 0x1000..0x100C; hit on 0x1008 with imemload=mem[0x1008].
- ICACHE_STATS_EN: 3 misses and 5 hits → miss_count=3, hit_count=5; iflush leaves both unchanged.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_pkg.sv
// Instruction cache types and address-field width helpers.
package icache_pkg;
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} icache_state_t;

  // Word-offset / fill-counter width; kept at least 1 bit for single-word blocks.
  function automatic int offset_w(input int block_words);
    return (block_words > 1) ? $clog2(block_words) : 1;
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  // Tag covers the word-address bits above offset and index.
  function automatic int tag_w(input int sets, input int block_words);
    return 30 - $clog2(sets) - $clog2(block_words);
  endfunction

  // Way-number / round-robin pointer width; at least 1 bit for direct-mapped.
  function automatic int ptr_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/icache_way.sv
// One cache way: valid bits, tag array and block data with combinational read.
module icache_way
  import icache_pkg::*;
  import cpu_types_pkg::*;
#(
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 2,
  parameter int IW          = index_w(SETS),
  parameter int OW          = offset_w(BLOCK_WORDS),
  parameter int TW          = tag_w(SETS, BLOCK_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_en,
  input  logic          set_valid,
  input  logic [IW-1:0] wr_index,
  input  logic [OW-1:0] wr_offset,
  input  word_t         wr_data,
  input  logic [TW-1:0] wr_tag,
  input  logic [IW-1:0] rd_index,
  input  logic [OW-1:0] rd_offset,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output word_t         rd_word
);
  logic [SETS-1:0] valid_reg;
  logic [TW-1:0]   tag_mem  [SETS];
  word_t           data_mem [SETS][BLOCK_WORDS];

  // Valid bits: cleared by reset or flush, set when a line's last word lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else if (set_valid) begin
      valid_reg[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage are not reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_index][wr_offset] <= wr_data;
    end
    if (set_valid) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_word  = data_mem[rd_index][rd_offset];
endmodule

// File: rtl/icache_assoc.sv
// Set-associative multi-word-block instruction cache with per-set round-robin
// replacement. Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_assoc
  import icache_pkg::*;
  import cpu_types_pkg::*;
#(
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output word_t       imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  word_t       iload,
  input  logic        iwait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int IW = index_w(SETS);
  localparam int OW = offset_w(BLOCK_WORDS);
  localparam int TW = tag_w(SETS, BLOCK_WORDS);
  localparam int PW = ptr_w(WAYS);
  localparam int BO = $clog2(BLOCK_WORDS);

  icache_state_t state_reg, state_next;
  logic [OW-1:0] cnt_reg;
  logic [TW-1:0] fill_tag_reg;
  logic [IW-1:0] fill_index_reg;
  logic [PW-1:0] victim_reg;
  logic          victim_rr_reg;
  logic [PW-1:0] rr_ptr_reg [SETS];

  // Request address split into tag / index / word offset.
  logic [29:0]   word_addr;
  logic [OW-1:0] req_offset;
  logic [IW-1:0] req_index;
  logic [TW-1:0] req_tag;
  logic          unused_addr_bits;

  assign word_addr        = imemaddr[31:2];
  assign req_offset       = OW'(word_addr & 30'(BLOCK_WORDS - 1));
  assign req_index        = IW'(word_addr >> BO);
  assign req_tag          = TW'(word_addr >> (BO + IW));
  assign unused_addr_bits = ^imemaddr[1:0];

  logic [WAYS-1:0] way_valid;
  logic [TW-1:0]   way_tag  [WAYS];
  word_t           way_word [WAYS];

  logic fill_we, fill_last, fill_last_we;
  assign fill_we      = (state_reg == FILL) && !iwait && !iflush;
  assign fill_last    = (cnt_reg == OW'(BLOCK_WORDS - 1));
  assign fill_last_we = fill_we && fill_last;

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      icache_way #(
        .SETS(SETS), .BLOCK_WORDS(BLOCK_WORDS)
      ) u_way (
        .clk      (CLK),
        .rst_n    (nRST),
        .flush    (iflush),
        .wr_en    (fill_we && (victim_reg == PW'(gi))),
        .set_valid(fill_last_we && (victim_reg == PW'(gi))),
        .wr_index (fill_index_reg),
        .wr_offset(cnt_reg),
        .wr_data  (iload),
        .wr_tag   (fill_tag_reg),
        .rd_index (req_index),
        .rd_offset(req_offset),
        .rd_valid (way_valid[gi]),
        .rd_tag   (way_tag[gi]),
        .rd_word  (way_word[gi])
      );
    end
  endgenerate

  // Tag compare across the indexed set; the lowest matching way wins.
  logic  match;
  word_t match_word;
  always_comb begin
    match      = 1'b0;
    match_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!match && way_valid[w] && (way_tag[w] == req_tag)) begin
        match      = 1'b1;
        match_word = way_word[w];
      end
    end
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer.
  logic          inv_found;
  logic [PW-1:0] victim_sel;
  always_comb begin
    inv_found  = 1'b0;
    victim_sel = rr_ptr_reg[req_index];
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !way_valid[w]) begin
        inv_found  = 1'b1;
        victim_sel = PW'(w);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state: flush always returns to IDLE; a miss starts a fill.
  always_comb begin
    state_next = state_reg;
    if (iflush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (imemREN && !match) state_next = FILL;
        FILL:    if (fill_last_we)      state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs: same-cycle hit data in IDLE, memory request while filling.
  logic [29:0] fill_word;
  assign fill_word = (30'(fill_tag_reg) << (BO + IW)) | (30'(fill_index_reg) << BO) | 30'(cnt_reg);

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    case (state_reg)
      IDLE: begin
        if (imemREN && match && !iflush) begin
          ihit     = 1'b1;
          imemload = match_word;
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = {fill_word, 2'b00};
      end
      default: ;
    endcase
  end

  // Fill bookkeeping: latch the missing line, count words, advance pointers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_reg        <= '0;
      fill_tag_reg   <= '0;
      fill_index_reg <= '0;
      victim_reg     <= '0;
      victim_rr_reg  <= 1'b0;
      for (int s = 0; s < SETS; s++) rr_ptr_reg[s] <= '0;
    end else if (iflush) begin
      cnt_reg <= '0;
    end else if ((state_reg == IDLE) && (state_next == FILL)) begin
      cnt_reg        <= '0;
      fill_tag_reg   <= req_tag;
      fill_index_reg <= req_index;
      victim_reg     <= victim_sel;
      victim_rr_reg  <= !inv_found;
    end else if (fill_we) begin
      if (fill_last) begin
        cnt_reg <= '0;
        if (victim_rr_reg && (WAYS > 1)) begin
          rr_ptr_reg[fill_index_reg] <= rr_ptr_reg[fill_index_reg] + PW'(1);
        end
      end else begin
        cnt_reg <= cnt_reg + OW'(1);
      end
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating event counters; untouched by flush.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit && (hit_count != 32'hFFFF_FFFF)) hit_count <= hit_count + 32'd1;
      if ((state_reg == IDLE) && (state_next == FILL) && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule
